window_actuator: RTL and testbench
==================================

// Module: window_actuator
// PURPOSE
//  Downstream of the character-recognition stage. Consumes its 'window' command
//  level and drives the window motor (open/close) until the limit switches trip.
//  Enforces a direction-reversal dead time, a move timeout and a latched fault.
//  Optionally closes the window again automatically after a hold time.
// PARAMETERS
//  MOVE_TIMEOUT  1000  max cycles in OPENING/CLOSING before FAULT (>=2)
//  DEADTIME      4     cycles with both motor outputs off before any motion (>=1)
//  AUTO_CLOSE    5000  cycles in OPEN before auto-close (used only with macro)
//  CNT_W         16    counter width; must hold max(MOVE_TIMEOUT,AUTO_CLOSE)
// PORTS
//  clock         in   1  system clock, all logic on rising edge
//  reset         in   1  synchronous, active-low reset
//  window        in   1  open request level from character recognition
//  close_cmd     in   1  close request level (house controller)
//  limit_open    in   1  fully-open limit switch, active-high
//  limit_closed  in   1  fully-closed limit switch, active-high
//  motor_open    out  1  drive motor in open direction
//  motor_close   out  1  drive motor in close direction
//  is_open       out  1  window resting fully open
//  fault         out  1  latched fault indicator
// BEHAVIOUR
//  - Reset (reset==0 at clock edge): state CLOSED; counter=0; window_q=close_q=0;
//    all outputs 0. Reset mid-motion drops both motor outputs on the next edge.
//  - Requests are rising edges: open_req = window & ~window_q;
//    close_req = close_cmd & ~close_q. Edge registers update every cycle.
//  - Both requests in the same cycle: close_req wins, open_req is discarded.
//  - States: CLOSED, DEAD, OPENING, OPEN, CLOSING, FAULT. A 1-bit target register
//    holds the direction for DEAD.
//  - CLOSED: open_req -> DEAD (target=open), counter=0.
//  - DEAD: both motors off; counter++; when counter==DEADTIME-1, enter OPENING or
//    CLOSING per target, counter=0. A new request in DEAD overwrites target.
//  - OPENING: motor_open=1. limit_open -> OPEN. close_req -> DEAD (target=close).
//    counter==MOVE_TIMEOUT-1 without limit -> FAULT.
//  - OPEN: is_open=1; close_req -> DEAD (target=close); open_req ignored.
//  - CLOSING: motor_close=1. limit_closed -> CLOSED. open_req -> DEAD
//    (target=open). Timeout as OPENING.
//  - Priority within a moving state: limit > request > timeout.
//  - FAULT: motors off, fault=1; left only via reset. Entered from any state when
//    limit_open & limit_closed are both 1.
//  - Outputs decoded from registered state (Moore); motor_open and motor_close are
//    never 1 together. Latency: request edge sampled at edge k -> DEAD after k;
//    motor asserts DEADTIME cycles later.
//  - Counter saturates; never wraps.
// CONFIGURATION
//  WINDOW_AUTOCLOSE_EN defined: in OPEN the counter increments each cycle; at
//    AUTO_CLOSE-1 -> DEAD (target=close), as if close_req. A repeated window edge
//    in OPEN restarts the hold count.
//  Not defined: OPEN is held indefinitely until close_req; no auto-close logic.
// TESTING (bench overrides MOVE_TIMEOUT=20, DEADTIME=4, AUTO_CLOSE=30)
//  1 reset low 2 cycles, window 0->1 -> motor_open=1 exactly 4 cycles after the edge
//    sample; limit_open=1 -> next cycle motor_open=0, is_open=1.
//  2 in OPEN pulse close_cmd -> 4 cycles both motors 0, then motor_close=1;
//    limit_closed=1 -> CLOSED, all outputs 0.
//  3 OPENING with no limit for 20 cycles -> fault=1, motors 0; window toggles
//    ignored; reset low -> fault=0.
//  4 window and close_cmd rise same cycle from OPEN -> closing sequence only;
//    mid-OPENING close_cmd -> motor_open drops, 4 dead cycles, motor_close=1.
//  5 limit_open=limit_closed=1 in any state -> fault=1 next cycle, motors 0.
//  6 WINDOW_AUTOCLOSE_EN: after OPEN, no input for 30 cycles -> DEAD then
//    motor_close=1; without macro, is_open stays 1 for 200 cycles.

Source files
------------

// File: rtl/window_actuator.sv
// Window motor actuator: edge-triggered open/close requests, reversal dead time,
// move timeout, latched fault. Optional auto-close enabled by WINDOW_AUTOCLOSE_EN.
module window_actuator #(
  parameter int MOVE_TIMEOUT = 1000,
  parameter int DEADTIME     = 4,
  parameter int AUTO_CLOSE   = 5000,
  parameter int CNT_W        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic window,
  input  logic close_cmd,
  input  logic limit_open,
  input  logic limit_closed,
  output logic motor_open,
  output logic motor_close,
  output logic is_open,
  output logic fault
);

  typedef enum logic [2:0] {
    S_CLOSED,
    S_DEAD,
    S_OPENING,
    S_OPEN,
    S_CLOSING,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam int CNT_NEED =
    (MOVE_TIMEOUT > AUTO_CLOSE) ? MOVE_TIMEOUT : AUTO_CLOSE;

  // the counter must reach the largest terminal count without wrapping
  if (((CNT_NEED - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("CNT_W too small for MOVE_TIMEOUT/AUTO_CLOSE");
  end

`ifdef WINDOW_AUTOCLOSE_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(AUTO_CLOSE - 1);
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tgt_open_q;
  logic             tgt_open_d;
  logic             window_q;
  logic             close_q;
  logic             open_req;
  logic             close_req;
  logic             open_go;
  logic             both_limits;

  // request edges and saturating counter increment
  always_comb begin
    open_req    = window & ~window_q;
    close_req   = close_cmd & ~close_q;
    open_go     = open_req & ~close_req;
    both_limits = limit_open & limit_closed;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  // state, counter, direction target and edge detector registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_CLOSED;
      cnt_q      <= '0;
      tgt_open_q <= 1'b0;
      window_q   <= 1'b0;
      close_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_open_q <= tgt_open_d;
      window_q   <= window;
      close_q    <= close_cmd;
    end
  end

  // next-state: limit beats request beats timeout while moving
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_open_d = tgt_open_q;
    if (both_limits) begin
      state_d = S_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_CLOSED: begin
          if (open_go) begin
            state_d    = S_DEAD;
            tgt_open_d = 1'b1;
            cnt_d      = '0;
          end
        end
        S_DEAD: begin
          if (close_req) begin
            tgt_open_d = 1'b0;
          end else if (open_go) begin
            tgt_open_d = 1'b1;
          end
          if (cnt_q == DEAD_LAST) begin
            state_d = tgt_open_d ? S_OPENING : S_CLOSING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_OPENING: begin
          if (limit_open) begin
            state_d = S_OPEN;
            cnt_d   = '0;
          end else if (close_req) begin
            state_d    = S_DEAD;
            tgt_open_d = 1'b0;
            cnt_d      = '0;
          end else if (cnt_q == MOVE_LAST) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_OPEN: begin
          if (close_req) begin
            state_d    = S_DEAD;
            tgt_open_d = 1'b0;
            cnt_d      = '0;
`ifdef WINDOW_AUTOCLOSE_EN
          end else if (open_req) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d    = S_DEAD;
            tgt_open_d = 1'b0;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
`endif
          end
        end
        S_CLOSING: begin
          if (limit_closed) begin
            state_d = S_CLOSED;
            cnt_d   = '0;
          end else if (open_go) begin
            state_d    = S_DEAD;
            tgt_open_d = 1'b1;
            cnt_d      = '0;
          end else if (cnt_q == MOVE_LAST) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs; one motor direction at most by construction
  always_comb begin
    motor_open  = 1'b0;
    motor_close = 1'b0;
    is_open     = 1'b0;
    fault       = 1'b0;
    case (state_q)
      S_OPENING: motor_open  = 1'b1;
      S_CLOSING: motor_close = 1'b1;
      S_OPEN:    is_open     = 1'b1;
      S_FAULT:   fault       = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_window_actuator.sv
// Scoreboard bench for window_actuator: directed scenarios then random traffic,
// expected outputs from a behavioural model queued and checked by a monitor.
module tb_window_actuator;

  localparam int MT = 20;
  localparam int DT = 4;
  localparam int AC = 30;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic window = 1'b0;
  logic close_cmd = 1'b0;
  logic limit_open = 1'b0;
  logic limit_closed = 1'b0;
  logic motor_open;
  logic motor_close;
  logic is_open;
  logic fault;

  window_actuator #(
    .MOVE_TIMEOUT(MT),
    .DEADTIME(DT),
    .AUTO_CLOSE(AC),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .window(window),
    .close_cmd(close_cmd),
    .limit_open(limit_open),
    .limit_closed(limit_closed),
    .motor_open(motor_open),
    .motor_close(motor_close),
    .is_open(is_open),
    .fault(fault)
  );

  always #5 clock = ~clock;

  // behavioural picture of the window: what it is doing and for how long
  typedef enum int {SHUT, PAUSE, RISING, UP, LOWERING, BROKEN} phase_t;
  phase_t ph = SHUT;
  bit     head_open = 0;
  int     age = 0;
  bit     pw = 0;
  bit     pc = 0;

  logic [3:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  task automatic model(input bit rn, input bit w, input bit c,
                       input bit lo, input bit lc);
    bit oreq;
    bit creq;
    if (!rn) begin
      ph = SHUT; age = 0; pw = 0; pc = 0;
      return;
    end
    oreq = w && !pw;
    creq = c && !pc;
    pw = w;
    pc = c;
    if (lo && lc) begin
      ph = BROKEN;
      return;
    end
    case (ph)
      SHUT:
        if (oreq && !creq) begin ph = PAUSE; head_open = 1; age = 0; end
      PAUSE: begin
        if (creq) head_open = 0;
        else if (oreq) head_open = 1;
        if (age + 1 == DT) begin
          ph = head_open ? RISING : LOWERING; age = 0;
        end else age++;
      end
      RISING:
        if (lo) begin ph = UP; age = 0; end
        else if (creq) begin ph = PAUSE; head_open = 0; age = 0; end
        else if (age + 1 == MT) ph = BROKEN;
        else age++;
      UP:
        if (creq) begin ph = PAUSE; head_open = 0; age = 0; end
`ifdef WINDOW_AUTOCLOSE_EN
        else if (oreq) age = 0;
        else if (age + 1 == AC) begin ph = PAUSE; head_open = 0; age = 0; end
        else age++;
`endif
      LOWERING:
        if (lc) begin ph = SHUT; age = 0; end
        else if (oreq && !creq) begin ph = PAUSE; head_open = 1; age = 0; end
        else if (age + 1 == MT) ph = BROKEN;
        else age++;
      default: ph = BROKEN;
    endcase
  endtask

  task automatic drive(input bit rn, input bit w, input bit c,
                       input bit lo, input bit lc);
    @(negedge clock);
    reset = rn; window = w; close_cmd = c;
    limit_open = lo; limit_closed = lc;
    model(rn, w, c, lo, lc);
    exp_q.push_back({ph == RISING, ph == LOWERING, ph == UP, ph == BROKEN});
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++)
      drive(1, window, close_cmd, limit_open, limit_closed);
  endtask

  // monitor: every cycle the DUT presents outputs, compare with the queue head
  always @(posedge clock) begin
    logic [3:0] e;
    logic [3:0] got;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {motor_open, motor_close, is_open, fault};
      checks++;
      if (got === e) passed++;
      else $display("FAIL outputs cyc=%0d {mo,mc,open,fault} got=%b exp=%b",
                    cyc, got, e);
    end
  end

  initial begin
    // 1: reset, open request, limit reached
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    hold(6);
    drive(1, 1, 0, 1, 0);
    hold(2);
    drive(1, 1, 0, 0, 0);
    // 2: close pulse from open, limit closed
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    hold(6);
    drive(1, 1, 0, 0, 1);
    hold(2);
    drive(1, 0, 0, 0, 0);
    // 3: opening timeout, window toggles ignored, reset clears
    drive(1, 1, 0, 0, 0);
    hold(28);
    for (int i = 0; i < 4; i++) drive(1, i[0], 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    // 4: simultaneous requests from open, then reversal mid-opening
    drive(1, 1, 0, 0, 0);
    hold(5);
    drive(1, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    hold(8);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    hold(6);
    drive(1, 1, 1, 0, 0);
    hold(8);
    drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    // 5: both limits in closed and in dead time
    drive(1, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 1);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // 6: rest in open for a long time
    drive(1, 1, 0, 0, 0);
    hold(5);
    drive(1, 1, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    hold(200);
    drive(0, 0, 0, 0, 0);
    // random traffic with limits biased by the model's motion
    for (int i = 0; i < 4000; i++) begin
      bit rn, w, c, lo, lc;
      rn = ($urandom % 150) != 0;
      w  = ($urandom % 12 == 0) ? !window : window;
      c  = ($urandom % 15 == 0) ? !close_cmd : close_cmd;
      lo = (ph == RISING) ? ($urandom % 8 == 0) : ($urandom % 40 == 0);
      lc = (ph == LOWERING) ? ($urandom % 8 == 0) : ($urandom % 40 == 0);
      drive(rn, w, c, lo, lc);
    end
    @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain left=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
